inst_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the cpu datapath and produces its 32-bit cmd.

---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/inst_fetch.sv | 103 ++++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and reset defaults.
package inst_fetch_pkg;

  localparam int unsigned INST_W       = 32;
  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, redirect/flush, FIFO to decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int unsigned     DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_cmd,
  output logic [XLEN-1:0]   out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = XLEN + INST_W;

  fetch_state_t      state, state_next;
  logic [XLEN-1:0]   fetch_pc, fetch_pc_next;
  logic [XLEN-1:0]   req_pc, req_pc_next;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              fire_c;
  logic              push_c;
  logic              pop_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  // Redirect overrides the fetch PC in every state; a response racing it is discarded.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    req_pc_next    = req_pc;
    imem_req_valid = 1'b0;
    fire_c         = 1'b0;
    push_c         = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = !rst && (count < CNT_W'(DEPTH));
        fire_c         = imem_req_valid && imem_req_ready;
        if (fire_c) begin
          req_pc_next   = fetch_pc;
          fetch_pc_next = fetch_pc + XLEN'(4);
          state_next    = redirect_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          push_c     = !redirect_valid;
          state_next = S_REQ;
        end else if (redirect_valid) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
    if (redirect_valid) fetch_pc_next = redirect_pc;
  end

  assign imem_req_addr = fetch_pc;
  assign out_valid     = (count != '0);
  assign pop_c         = out_valid && out_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push_c),
    .pop   (pop_c),
    .wdata ({req_pc, imem_resp_data}),
    .head  (head),
    .count (count)
  );

  assign out_pc  = head[ENT_W-1:INST_W];
  assign out_cmd = head[INST_W-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a simple 1-cycle instruction memory model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cmd;
  logic [31:0] out_pc;

  int checks = 0;
  int passed = 0;
  logic        mem_auto;
  logic        fire_s;
  logic [31:0] addr_s;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_cmd         (out_cmd),
    .out_pc          (out_pc)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock; the memory model answers an accepted request in the following cycle.
  task automatic tick();
    #2;
    fire_s = imem_req_valid & imem_req_ready;
    addr_s = imem_req_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_resp_valid = fire_s;
      imem_resp_data  = fire_s ? inst_of(addr_s) : 32'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0; mem_auto = 1'b0;
    tick(); tick();
    checks++;
    if ({imem_req_valid, out_valid, out_cmd, out_pc} !== 66'h0)
      $display("FAIL reset_outputs: got %h want 0", {imem_req_valid, out_valid, out_cmd, out_pc});
    else passed++;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    imem_req_ready = 1'b1; out_ready = 1'b1; mem_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = 32'h8000_0000 + 32'(4 * i);
      checks++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, exp})
        $display("FAIL seq_req%0d: got %h want %h", i, {imem_req_valid, imem_req_addr}, {1'b1, exp});
      else passed++;
      tick(); tick();
      checks++;
      if ({out_valid, out_pc, out_cmd} !== {1'b1, exp, inst_of(exp)})
        $display("FAIL seq_out%0d: got %h want %h", i, {out_valid, out_pc, out_cmd}, {1'b1, exp, inst_of(exp)});
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, imem_req_valid} !== {1'b1, 32'h8000_0008, 1'b0})
      $display("FAIL bp_full: got %h want %h", {out_valid, out_pc, imem_req_valid}, {1'b1, 32'h8000_0008, 1'b0});
    else passed++;
    ok = 1'b1;
    repeat (10) begin
      tick();
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h8000_0008) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) $display("FAIL bp_hold: got req_valid=%b out_pc=%h want 0/80000008", imem_req_valid, out_pc);
    else passed++;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_pc, out_cmd, imem_req_valid, imem_req_addr} !==
        {1'b1, 32'h8000_000C, inst_of(32'h8000_000C), 1'b1, 32'h8000_0010})
      $display("FAIL bp_pop: got %h want %h", {out_valid, out_pc, out_cmd, imem_req_valid, imem_req_addr},
               {1'b1, 32'h8000_000C, inst_of(32'h8000_000C), 1'b1, 32'h8000_0010});
    else passed++;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h8000_0010})
      $display("FAIL bp_resume: got %h want %h", {out_valid, out_pc}, {1'b1, 32'h8000_0010});
    else passed++;
  endtask

  task automatic test_redirect_wait();
    mem_auto = 1'b0; imem_resp_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, out_valid} !== 2'b00)
      $display("FAIL rw_drop: got %b want 00", {imem_req_valid, out_valid});
    else passed++;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0100, 1'b0})
      $display("FAIL rw_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0100, 1'b0});
    else passed++;
    mem_auto = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, out_cmd} !== {1'b1, 32'h8000_0100, inst_of(32'h8000_0100)})
      $display("FAIL rw_out: got %h want %h", {out_valid, out_pc, out_cmd}, {1'b1, 32'h8000_0100, inst_of(32'h8000_0100)});
    else passed++;
  endtask

  task automatic test_redirect_flush();
    out_ready = 1'b0; mem_auto = 1'b0; imem_resp_valid = 1'b0;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    checks++;
    if ({out_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0200})
      $display("FAIL rf_resp: got %h want %h", {out_valid, imem_req_valid, imem_req_addr}, {1'b0, 1'b1, 32'h8000_0200});
    else passed++;
    mem_auto = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if ({out_valid, out_pc, imem_req_valid} !== {1'b1, 32'h8000_0200, 1'b0})
      $display("FAIL rf_fill: got %h want %h", {out_valid, out_pc, imem_req_valid}, {1'b1, 32'h8000_0200, 1'b0});
    else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0300})
      $display("FAIL rf_full: got %h want %h", {out_valid, imem_req_valid, imem_req_addr}, {1'b0, 1'b1, 32'h8000_0300});
    else passed++;
    out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, out_cmd} !== {1'b1, 32'h8000_0300, inst_of(32'h8000_0300)})
      $display("FAIL rf_out: got %h want %h", {out_valid, out_pc, out_cmd}, {1'b1, 32'h8000_0300, inst_of(32'h8000_0300)});
    else passed++;
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_req_valid, out_valid} !== 2'b00)
      $display("FAIL wrap_drop: got %b want 00", {imem_req_valid, out_valid});
    else passed++;
    tick();
    checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL wrap_req: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'hFFFF_FFFC, 1'b0});
    else passed++;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, out_cmd, imem_req_valid, imem_req_addr} !==
        {1'b1, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1'b1, 32'h0000_0000})
      $display("FAIL wrap_next: got %h want %h", {out_valid, out_pc, out_cmd, imem_req_valid, imem_req_addr},
               {1'b1, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1'b1, 32'h0000_0000});
    else passed++;
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0; imem_resp_valid = 1'b0;
    tick();
    checks++;
    if ({imem_req_valid, out_valid} !== 2'b00)
      $display("FAIL rm_wait: got %b want 00", {imem_req_valid, out_valid});
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr, out_valid, out_cmd, out_pc} !== {1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0})
      $display("FAIL rm_after: got %h want %h", {imem_req_valid, imem_req_addr, out_valid, out_cmd, out_pc},
               {1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0});
    else passed++;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h8000_0000, 1'b0})
      $display("FAIL rm_stale: got %h want %h", {imem_req_valid, imem_req_addr, out_valid}, {1'b1, 32'h8000_0000, 1'b0});
    else passed++;
    imem_req_ready = 1'b1; mem_auto = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_pc, out_cmd} !== {1'b1, 32'h8000_0000, inst_of(32'h8000_0000)})
      $display("FAIL rm_first: got %h want %h", {out_valid, out_pc, out_cmd}, {1'b1, 32'h8000_0000, inst_of(32'h8000_0000)});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
